// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM pipeline stage. It runs the req/ack data-memory access,
// stalls the pipeline until the bus answers, and latches the MEM/WB register.
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic        alu_zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [31:0] pc_branch,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] pc_branch_out,
  output logic        bus_error,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic [31:0] alu_out_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  reg_addr_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rbuf;
  logic        r_bus_error;

  logic        w_op;
  logic        w_stall;
  logic [7:0]  w_cnt_nxt;
  logic        w_timeout;
  logic [7:0]  w_lane;
  logic [31:0] w_fmt;

  assign w_op      = mem_read | mem_write;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_nxt == C_LAST);
  // Gating with reset lets a request vanish in the very cycle reset rises.
  assign w_stall   = ~reset & w_op & (r_state != S_DONE);

  assign mem_req   = ~reset & (((r_state == S_IDLE) & w_op) | (r_state == S_WAIT));
  assign mem_wr    = mem_write;
  assign mem_addr  = mem_type ? alu_out : {alu_out[31:2], 2'b00};
  assign mem_be    = mem_type ? (4'b0001 << alu_out[1:0]) : 4'b1111;
  assign mem_wdata = mem_type ? {4{data_t[7:0]}} : data_t;

  assign stall         = w_stall;
  assign bus_error     = r_bus_error;
  assign branch_taken  = is_branch & alu_zero;
  assign pc_branch_out = pc_branch;
  assign reg_probe     = reg_addr;
  assign data_probe    = alu_out;
  assign write_probe   = reg_write & ~mem_to_reg;

  always_comb begin
    w_lane = r_rbuf[7:0];
    case (alu_out[1:0])
      2'd0: w_lane = r_rbuf[7:0];
      2'd1: w_lane = r_rbuf[15:8];
      2'd2: w_lane = r_rbuf[23:16];
      2'd3: w_lane = r_rbuf[31:24];
    endcase
    w_fmt = mem_type ? {{24{w_lane[7]}}, w_lane} : r_rbuf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_rbuf      <= 32'd0;
      r_bus_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            r_cnt <= 8'd0;
            if (mem_ack) begin
              r_rbuf  <= mem_rdata;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_rbuf  <= mem_rdata;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rbuf      <= 32'd0;
            r_bus_error <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          if (we) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A stalled advance inserts a bubble; data fields keep their old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      alu_out_out    <= 32'd0;
      mem_data_out   <= 32'd0;
      reg_addr_out   <= 5'd0;
    end else if (we) begin
      if (w_stall) begin
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else begin
        reg_write_out  <= reg_write;
        mem_to_reg_out <= mem_to_reg;
        alu_out_out    <= alu_out;
        reg_addr_out   <= reg_addr;
        if (w_op) mem_data_out <= w_fmt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (TIMEOUT = 4).
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, is_branch, alu_zero, mem_read, mem_write, mem_type;
  logic        mem_to_reg, reg_write, mem_ack;
  logic [31:0] pc_branch, alu_out, data_t, mem_rdata;
  logic [4:0]  reg_addr;
  logic        mem_req, mem_wr, stall, branch_taken, bus_error, write_probe;
  logic        reg_write_out, mem_to_reg_out;
  logic [31:0] mem_addr, mem_wdata, pc_branch_out, data_probe, alu_out_out, mem_data_out;
  logic [3:0]  mem_be;
  logic [4:0]  reg_probe, reg_addr_out;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .we(we), .is_branch(is_branch), .alu_zero(alu_zero),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_branch(pc_branch),
    .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .branch_taken(branch_taken), .pc_branch_out(pc_branch_out), .bus_error(bus_error),
    .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .alu_out_out(alu_out_out), .mem_data_out(mem_data_out), .reg_addr_out(reg_addr_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we = 1'b1; is_branch = 1'b0; alu_zero = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_type = 1'b0; mem_to_reg = 1'b0;
    reg_write = 1'b0; mem_ack = 1'b0; pc_branch = 32'd0; alu_out = 32'd0;
    data_t = 32'd0; mem_rdata = 32'd0; reg_addr = 5'd0;
    next_cycle(); next_cycle();
    #1;
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_stall",     32'(stall), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_regwr_out", 32'(reg_write_out), 32'd0);
    check("rst_mdata_out", mem_data_out, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Load word, ack in the request cycle
    mem_read = 1'b1; mem_type = 1'b0; alu_out = 32'h100; reg_write = 1'b1;
    mem_to_reg = 1'b1; reg_addr = 5'd5; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req",   32'(mem_req), 32'd1);
    check("lw_be",    32'(mem_be), 32'hF);
    check("lw_addr",  mem_addr, 32'h100);
    check("lw_wr",    32'(mem_wr), 32'd0);
    check("lw_stall", 32'(stall), 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    #1;
    check("lw_stall_done", 32'(stall), 32'd0);
    check("lw_req_done",   32'(mem_req), 32'd0);
    check("lw_bubble_m2r", 32'(mem_to_reg_out), 32'd0);
    next_cycle();
    check("lw_mdata", mem_data_out, 32'hDEADBEEF);
    check("lw_m2r",   32'(mem_to_reg_out), 32'd1);
    check("lw_rwr",   32'(reg_write_out), 32'd1);
    check("lw_raddr", 32'(reg_addr_out), 32'd5);
    check("lw_alu",   alu_out_out, 32'h100);

    // Store byte, ack one cycle after the request
    mem_read = 1'b0; mem_write = 1'b1; mem_type = 1'b1; alu_out = 32'h102;
    data_t = 32'h12345678; reg_write = 1'b0; mem_to_reg = 1'b0; mem_rdata = 32'd0;
    #1;
    check("sb_addr",  mem_addr, 32'h102);
    check("sb_be",    32'(mem_be), 32'h4);
    check("sb_wdata", mem_wdata, 32'h78787878);
    check("sb_wr",    32'(mem_wr), 32'd1);
    check("sb_req",   32'(mem_req), 32'd1);
    next_cycle();
    mem_ack = 1'b1;
    #1;
    check("sb_stall_wait", 32'(stall), 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    #1;
    check("sb_stall_done", 32'(stall), 32'd0);
    next_cycle();

    // Load byte, ack three cycles after the request
    mem_write = 1'b0; mem_read = 1'b1; mem_type = 1'b1; alu_out = 32'h203;
    mem_rdata = 32'h80FFFFFF; reg_write = 1'b1; mem_to_reg = 1'b1; reg_addr = 5'd9;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      check($sformatf("lb_stall_%0d", i), 32'(stall), 32'd1);
      next_cycle();
    end
    mem_ack = 1'b0;
    #1;
    check("lb_stall_end", 32'(stall), 32'd0);
    next_cycle();
    check("lb_mdata", mem_data_out, 32'hFFFFFF80);
    check("lb_raddr", 32'(reg_addr_out), 32'd9);

    // Timeout: no ack at all
    mem_type = 1'b0; alu_out = 32'h300; mem_rdata = 32'h55555555; reg_addr = 5'd10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_stall_%0d", i), 32'(stall), 32'd1);
      check($sformatf("to_err_%0d", i), 32'(bus_error), 32'd0);
      next_cycle();
    end
    #1;
    check("to_stall_end", 32'(stall), 32'd0);
    check("to_err_set",   32'(bus_error), 32'd1);
    next_cycle();
    check("to_mdata", mem_data_out, 32'd0);

    // Normal access after the timeout
    alu_out = 32'h104; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; reg_addr = 5'd11;
    #1;
    check("post_to_stall", 32'(stall), 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    #1;
    check("post_to_stall_end", 32'(stall), 32'd0);
    next_cycle();
    check("post_to_mdata", mem_data_out, 32'h0BADF00D);
    check("post_to_err",   32'(bus_error), 32'd1);

    // Branch, no memory operation
    mem_read = 1'b0; is_branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h40;
    alu_out = 32'h77; reg_write = 1'b1; mem_to_reg = 1'b0; reg_addr = 5'd3;
    #1;
    check("br_taken",   32'(branch_taken), 32'd1);
    check("br_pc",      pc_branch_out, 32'h40);
    check("br_stall",   32'(stall), 32'd0);
    check("br_wprobe",  32'(write_probe), 32'd1);
    check("br_dprobe",  data_probe, 32'h77);
    check("br_rprobe",  32'(reg_probe), 32'd3);
    alu_zero = 1'b0;
    #1;
    check("br_not_taken", 32'(branch_taken), 32'd0);
    next_cycle();
    check("alu_alu_out",  alu_out_out, 32'h77);
    check("alu_rwr",      32'(reg_write_out), 32'd1);
    check("alu_mdata_keep", mem_data_out, 32'h0BADF00D);
    is_branch = 1'b0;

    // Reset asserted while the access is waiting
    mem_read = 1'b1; alu_out = 32'h400; mem_ack = 1'b0; reg_addr = 5'd12;
    next_cycle();
    #1;
    check("rw_stall_wait", 32'(stall), 32'd1);
    check("rw_req_wait",   32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_req",       32'(mem_req), 32'd0);
    check("rw_stall",     32'(stall), 32'd0);
    check("rw_err",       32'(bus_error), 32'd0);
    check("rw_rwr_out",   32'(reg_write_out), 32'd0);
    check("rw_m2r_out",   32'(mem_to_reg_out), 32'd0);
    check("rw_alu_out",   alu_out_out, 32'd0);
    check("rw_mdata_out", mem_data_out, 32'd0);
    check("rw_raddr_out", 32'(reg_addr_out), 32'd0);
    next_cycle();
    reset = 1'b0;
    alu_out = 32'h108; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; reg_addr = 5'd13;
    #1;
    check("rr_stall", 32'(stall), 32'd1);
    next_cycle();
    mem_ack = 1'b0;
    #1;
    check("rr_stall_end", 32'(stall), 32'd0);
    next_cycle();
    check("rr_mdata", mem_data_out, 32'hCAFEF00D);
    check("rr_raddr", 32'(reg_addr_out), 32'd13);
    check("rr_err",   32'(bus_error), 32'd0);
    mem_read = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage of the MIPS core: consumes the EX/MEM register outputs of the execute stage and performs the data-memory access over a req/ack bus. It stalls the pipeline until the bus acknowledges, then latches the MEM/WB register. It also resolves conditional branches and publishes a forwarding probe for the hazard/forwarding unit.

## Interface

**Parameters**
- `TIMEOUT`, 16: maximum cycles `mem_req` may stay high without `mem_ack` before the access is aborted (2..255).

**Ports**
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `we` in 1: pipeline advance enable from the hazard unit.
- `is_branch`, `alu_zero`, `mem_read`, `mem_write`, `mem_type`, `mem_to_reg`, `reg_write` in 1 each: EX/MEM control. `mem_type`: 0 = word, 1 = byte.
- `pc_branch`, `alu_out`, `data_t` in 32 each: branch target, ALU result/address, store data.
- `reg_addr` in 5: destination register.
- `mem_req` out 1: bus request.
- `mem_wr` out 1: 1 = store, 0 = load.
- `mem_addr` out 32: access address.
- `mem_wdata` out 32: store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: load data.
- `stall` out 1: freeze the PC, IF/ID, ID/EX and EX/MEM registers.
- `branch_taken` out 1: `is_branch & alu_zero`.
- `pc_branch_out` out 32: equals `pc_branch`.
- `bus_error` out 1: sticky timeout flag.
- `reg_probe` out 5, `data_probe` out 32, `write_probe` out 1: forwarding probe.
- `reg_write_out`, `mem_to_reg_out` out 1 each; `alu_out_out`, `mem_data_out` out 32 each; `reg_addr_out` out 5: MEM/WB register.

## Operation

- `op = mem_read | mem_write`. Both asserted together is treated as a store.
- FSM states:
  - IDLE: if `op`, then `mem_req = 1` combinationally, the timeout counter is cleared, and the FSM goes to WAIT unless `mem_ack` is high in this same cycle, in which case it goes straight to DONE. With no `op`, the FSM stays in IDLE.
  - WAIT: `mem_req = 1`. On `mem_ack`, go to DONE. Otherwise increment the counter. When the counter reaches `TIMEOUT - 1` without an ack, go to DONE and set `bus_error`.
  - DONE: `mem_req = 0`. On `we`, go to IDLE; otherwise hold in DONE.
- `stall = op & (state != DONE)`.
- On the edge where `mem_ack` is sampled, `rbuf <= mem_rdata`. On a timeout abort, `rbuf <= 0`.
- Word access: `mem_addr = {alu_out[31:2], 2'b00}`, `mem_be = 4'b1111`, `mem_wdata = data_t`.
- Byte access (little-endian): `mem_addr = alu_out`, `mem_be = 1 << alu_out[1:0]`, `mem_wdata = {4{data_t[7:0]}}`.
- Load data:
  - Word: `mem_data_out <= rbuf`.
  - Byte: the lane selected by `alu_out[1:0]`, sign-extended to 32 bits.
- MEM/WB register loads on `we & ~stall`:
  - `reg_write_out <= reg_write`
  - `mem_to_reg_out <= mem_to_reg`
  - `alu_out_out <= alu_out`
  - `reg_addr_out <= reg_addr`
  - `mem_data_out <= formatted rbuf`, or the previous value when `op` is 0.
- When `we & stall`, the MEM/WB register loads a bubble: `reg_write_out = 0` and `mem_to_reg_out = 0`; the other MEM/WB outputs keep their values.
- Forwarding probe: `reg_probe = reg_addr`, `data_probe = alu_out`, `write_probe = reg_write & ~mem_to_reg`. Load results are forwarded from WB, not from this probe.
- `bus_error` is sticky until reset and never blocks later accesses.

## Timing

- Reset (asynchronous): state = IDLE, counter = 0, `rbuf = 0`, `bus_error = 0`, and every MEM/WB output = 0.
  - `mem_req` is gated by `~reset`, so it is 0 while `reset` is high.
  - All combinational outputs follow their inputs.
- Non-memory instruction: no stall; the MEM/WB register updates on the next `we` edge (1-cycle latency).
- Memory access with the ack in the request cycle: `stall` is high for 1 cycle; the instruction sits in MEM for 2 cycles.
- Ack N cycles after the request: `stall` is high for N + 1 cycles.
- Timeout: `stall` is high for `TIMEOUT` cycles; the load returns 0.
- Inputs from EX are held stable by `stall`. The bus may sample `mem_addr`, `mem_wdata` and `mem_be` on any cycle in which `mem_req` is high.
- `we = 0` in DONE: the FSM holds DONE with `mem_req = 0`, and no second bus access is issued.
- Reset during WAIT: `mem_req` drops in the same cycle and the access is abandoned; the bus must tolerate a dropped request.
- `mem_ack` outside WAIT, or outside IDLE with `op`, is ignored.

## Test plan

- Load word: `alu_out = 0x100`, `mem_read = 1`, `mem_type = 0`, `mem_ack` in the request cycle with `mem_rdata = 0xDEADBEEF`.
  - Required: `mem_be = 4'hF`, `stall` high for 1 cycle, `mem_data_out = 0xDEADBEEF` and `mem_to_reg_out = 1` after the advance.
- Store byte: `alu_out = 0x102`, `data_t = 0x12345678`, `mem_write = 1`, `mem_type = 1`.
  - Required: `mem_addr = 0x102`, `mem_be = 4'b0100`, `mem_wdata = 0x78787878`, `mem_wr = 1`.
- Load byte with `mem_ack` 3 cycles late: `alu_out = 0x203`, `mem_rdata = 0x80FFFFFF`.
  - Required: `stall` high for 4 cycles, `mem_data_out = 0xFFFFFF80`.
- No ack, `TIMEOUT = 4`.
  - Required: `stall` high for 4 cycles, then `bus_error = 1` (sticky), load data 0.
  - A subsequent access completes normally with `bus_error` still 1.
- `is_branch = 1`, `alu_zero = 1`, `pc_branch = 0x40`.
  - Required: `branch_taken = 1` and `pc_branch_out = 0x40` with no stall.
  - With `alu_zero = 0`: `branch_taken = 0`.
- Reset asserted mid-WAIT.
  - Required: `mem_req`, `stall` and `bus_error` are 0 in the same cycle; all MEM/WB outputs are 0; the FSM is in IDLE.
  - After reset release, a fresh load completes normally.
